// File: rtl/input_capture.sv
// Serial input capture: timestamps the first rising edge after refStrobe and measures pulse
// width at SERDES-bit resolution. Define INPUT_CAPTURE_FALL_EN to enable falling-edge/width capture.
module input_capture #(
  parameter int unsigned SERDES_WIDTH    = 4,
  parameter int unsigned COUNT_WIDTH     = 22,
  parameter int unsigned FIFO_ADDR_WIDTH = 4
) (
  input  logic                                         evrClk,
  input  logic                                         evrRst_n,
  input  logic                                         refStrobe,
  input  logic [SERDES_WIDTH-1:0]                      serdesPattern,
  input  logic                                         polarity,
  input  logic [COUNT_WIDTH-1:0]                       timeoutCount,
  output logic                                         eventValid,
  input  logic                                         eventReady,
  output logic [COUNT_WIDTH+$clog2(SERDES_WIDTH)-1:0]  eventDelay,
  output logic [COUNT_WIDTH+$clog2(SERDES_WIDTH)-1:0]  eventWidth,
  output logic [1:0]                                   eventStatus,
  output logic [7:0]                                   restartCount,
  output logic [7:0]                                   dropCount
);

  localparam int unsigned FINE_WIDTH  = $clog2(SERDES_WIDTH);
  localparam int unsigned TIME_WIDTH  = COUNT_WIDTH + FINE_WIDTH;
  localparam int unsigned DEPTH       = 2 ** FIFO_ADDR_WIDTH;
  localparam int unsigned PTR_WIDTH   = FIFO_ADDR_WIDTH + 1;
  localparam int unsigned ENTRY_WIDTH = 2 * TIME_WIDTH + 2;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_RISE = 2'd1;
  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_TO_RISE  = 2'd1;
`ifdef INPUT_CAPTURE_FALL_EN
  localparam logic [1:0] S_WAIT_FALL = 2'd2;
  localparam logic [1:0] ST_TO_FALL  = 2'd2;
`endif

  logic [1:0]                   state_q, state_d;
  logic [COUNT_WIDTH-1:0]       tick_q, tick_d;
  logic                         last_bit_q, last_bit_d;
  logic [7:0]                   restart_q, restart_d;
  logic [7:0]                   drop_q, drop_d;
  logic [PTR_WIDTH-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [ENTRY_WIDTH-1:0]       mem_q [DEPTH];
  logic [ENTRY_WIDTH-1:0]       mem_d [DEPTH];
  logic [ENTRY_WIDTH-1:0]       head_q, head_d;
  logic                         valid_q, valid_d;
`ifdef INPUT_CAPTURE_FALL_EN
  logic [TIME_WIDTH-1:0]        rise_time_q, rise_time_d;
`endif

  logic [SERDES_WIDTH-1:0]      w, p, rise_v;
  logic                         rise_found;
  logic [FINE_WIDTH-1:0]        rise_idx;
  logic [TIME_WIDTH-1:0]        tick_base, rise_time_now;
  logic [COUNT_WIDTH-1:0]       timeout_eff;
  logic                         timeout_hit;
  logic                         post, abort, push, pop, full;
  logic [TIME_WIDTH-1:0]        post_delay, post_width;
  logic [1:0]                   post_status;
  logic [PTR_WIDTH-1:0]         fill;
  logic [ENTRY_WIDTH-1:0]       new_entry;

  // p[i] is the sample one bit-time before w[i]
  assign w      = serdesPattern ^ {SERDES_WIDTH{polarity}};
  assign p      = {w[SERDES_WIDTH-2:0], last_bit_q};
  assign rise_v = w & ~p;

  always_comb begin : rise_enc
    rise_found = 1'b0;
    rise_idx   = '0;
    for (int i = SERDES_WIDTH - 1; i >= 0; i--) begin
      if (rise_v[i]) begin
        rise_found = 1'b1;
        rise_idx   = FINE_WIDTH'(i);
      end
    end
  end

`ifdef INPUT_CAPTURE_FALL_EN
  logic [SERDES_WIDTH-1:0] fall_v;
  logic                    fall_found, fall_after_found;
  logic [FINE_WIDTH-1:0]   fall_idx, fall_after_idx;

  assign fall_v = ~w & p;

  // Lowest fall in the word, and lowest fall strictly after the rise
  always_comb begin : fall_enc
    fall_found       = 1'b0;
    fall_idx         = '0;
    fall_after_found = 1'b0;
    fall_after_idx   = '0;
    for (int i = SERDES_WIDTH - 1; i >= 0; i--) begin
      if (fall_v[i]) begin
        fall_found = 1'b1;
        fall_idx   = FINE_WIDTH'(i);
        if (FINE_WIDTH'(i) > rise_idx) begin
          fall_after_found = 1'b1;
          fall_after_idx   = FINE_WIDTH'(i);
        end
      end
    end
  end
`endif

  assign tick_base     = {tick_q, {FINE_WIDTH{1'b0}}};
  assign rise_time_now = tick_base + TIME_WIDTH'(rise_idx);
  assign timeout_eff   = (timeoutCount == '0) ? '1 : timeoutCount;
  assign timeout_hit   = (tick_q == timeout_eff);

  always_comb begin : fsm_next
    state_d     = state_q;
    tick_d      = (tick_q == '1) ? tick_q : tick_q + COUNT_WIDTH'(1);
    last_bit_d  = w[SERDES_WIDTH-1];
    post        = 1'b0;
    post_delay  = '0;
    post_width  = '0;
    post_status = ST_OK;
    abort       = 1'b0;
`ifdef INPUT_CAPTURE_FALL_EN
    rise_time_d = rise_time_q;
`endif
    case (state_q)
      S_IDLE: ;
      S_WAIT_RISE: begin
        if (rise_found) begin
`ifdef INPUT_CAPTURE_FALL_EN
          rise_time_d = rise_time_now;
          if (fall_after_found) begin
            post       = 1'b1;
            post_delay = rise_time_now;
            post_width = TIME_WIDTH'(fall_after_idx) - TIME_WIDTH'(rise_idx);
            state_d    = S_IDLE;
          end else begin
            state_d    = S_WAIT_FALL;
          end
`else
          post       = 1'b1;
          post_delay = rise_time_now;
          state_d    = S_IDLE;
`endif
        end else if (timeout_hit) begin
          post        = 1'b1;
          post_delay  = '1;
          post_status = ST_TO_RISE;
          state_d     = S_IDLE;
        end
      end
`ifdef INPUT_CAPTURE_FALL_EN
      S_WAIT_FALL: begin
        if (fall_found) begin
          post       = 1'b1;
          post_delay = rise_time_q;
          post_width = tick_base + TIME_WIDTH'(fall_idx) - rise_time_q;
          state_d    = S_IDLE;
        end else if (timeout_hit) begin
          post        = 1'b1;
          post_delay  = rise_time_q;
          post_width  = tick_base + TIME_WIDTH'(SERDES_WIDTH) - rise_time_q;
          post_status = ST_TO_FALL;
          state_d     = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    // A strobe overrides: a completing result still posts, otherwise the measurement is aborted
    if (refStrobe) begin
      tick_d  = COUNT_WIDTH'(1);
      state_d = S_WAIT_RISE;
      abort   = (state_q != S_IDLE) && !post;
    end
  end

  assign fill      = wr_q - rd_q;
  assign full      = (fill == PTR_WIDTH'(DEPTH));
  assign pop       = valid_q & eventReady;
  assign push      = post & (~full | pop);
  assign new_entry = {post_status, post_delay, post_width};

  // FWFT FIFO; head is pre-registered so outputs come straight from flops
  always_comb begin : fifo_next
    wr_d   = wr_q + PTR_WIDTH'(push);
    rd_d   = rd_q + PTR_WIDTH'(pop);
    mem_d  = mem_q;
    if (push) mem_d[wr_q[FIFO_ADDR_WIDTH-1:0]] = new_entry;
    head_d = (push && (wr_q == rd_d)) ? new_entry : mem_q[rd_d[FIFO_ADDR_WIDTH-1:0]];
    valid_d   = (wr_d != rd_d);
    restart_d = (abort && restart_q != 8'hFF) ? restart_q + 8'd1 : restart_q;
    drop_d    = (post && !push && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge evrClk or negedge evrRst_n) begin
    if (!evrRst_n) begin
      state_q     <= S_IDLE;
      tick_q      <= '0;
      last_bit_q  <= 1'b0;
      restart_q   <= '0;
      drop_q      <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      mem_q       <= '{default: '0};
      head_q      <= '0;
      valid_q     <= 1'b0;
`ifdef INPUT_CAPTURE_FALL_EN
      rise_time_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      last_bit_q  <= last_bit_d;
      restart_q   <= restart_d;
      drop_q      <= drop_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      mem_q       <= mem_d;
      head_q      <= head_d;
      valid_q     <= valid_d;
`ifdef INPUT_CAPTURE_FALL_EN
      rise_time_q <= rise_time_d;
`endif
    end
  end

  assign eventValid                            = valid_q;
  assign {eventStatus, eventDelay, eventWidth} = head_q;
  assign restartCount                          = restart_q;
  assign dropCount                             = drop_q;

endmodule
